// File: rtl/lsu_mem_port_if.sv
// ----------------------------------------------------------------------------
// lsu_mem_port_if
//
// Bundles the three buses of the load/store unit: the CPU-side request
// handshake, the ordered response handshake and the word-addressed data
// memory port.
//
//   req_*   : request from the MEM stage (valid/ready, we, size, unsigned,
//             byte address, right-aligned store data)
//   resp_*  : ordered response (valid/ready, formatted load data, error)
//   mem_*   : data memory port (address, store data, write enable, store
//             size code, combinational read word)
//
// Modports:
//   slave  : the load/store unit itself
//   master : its environment (CPU MEM stage plus the data memory model)
// ----------------------------------------------------------------------------
interface lsu_mem_port_if #(
    parameter int unsigned MEM_AW = 12
);
    // Request channel
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;

    // Data memory port
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [31:0]       mem_dout;

    // Response channel
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output mem_addr, mem_din, mem_we, mem_size,
        input  mem_dout,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready
    );

    // Environment view: drives requests, consumes responses and plays the
    // memory (so it drives mem_dout).
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  mem_addr, mem_din, mem_we, mem_size,
        output mem_dout,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready
    );
endinterface

// File: rtl/lsu_mem_port.sv
// ----------------------------------------------------------------------------
// lsu_mem_port
//
// Load/store unit sitting between the CPU MEM stage and a 4 KB data memory.
// One request per cycle is accepted into slot s1; from s1 it drives the
// memory port and, when the response slot can take it, produces an ordered
// response: a write ack for stores or a sign/zero-extended, lane-aligned word
// for loads. Misaligned, out-of-range and reserved-size accesses never reach
// the memory and come back with resp_err set and zero data.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : lsu_mem_port_if.slave (request, response and memory buses)
//
// Pipeline:
//   s1   : accepted request (valid, we, size, unsigned, addr, wdata)
//   resp : response register (valid, rdata, err)
//   adv  : s1 moves into resp this cycle; the memory write (if any) happens
//          on the same edge, so a stalled store is written exactly once.
// ----------------------------------------------------------------------------
module lsu_mem_port #(
    parameter int unsigned MEM_AW = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    lsu_mem_port_if.slave   bus
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic        s1_valid_q,    s1_valid_d;
    logic        s1_we_q,       s1_we_d;
    logic [1:0]  s1_size_q,     s1_size_d;
    logic        s1_unsigned_q, s1_unsigned_d;
    logic [31:0] s1_addr_q,     s1_addr_d;
    logic [31:0] s1_wdata_q,    s1_wdata_d;

    logic        resp_valid_q,  resp_valid_d;
    logic [31:0] resp_rdata_q,  resp_rdata_d;
    logic        resp_err_q,    resp_err_d;

    // ------------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------------
    logic adv;
    logic accept;

    always_comb begin
        adv    = s1_valid_q && (!resp_valid_q || bus.resp_ready);
        accept = bus.req_valid && (!s1_valid_q || adv);
    end

    assign bus.req_ready = !s1_valid_q || adv;

    // ------------------------------------------------------------------------
    // Access legality for the request held in s1
    // ------------------------------------------------------------------------
    logic s1_align_err;
    logic s1_range_err;
    logic s1_err;

    always_comb begin
        s1_align_err = 1'b0;
        unique case (s1_size_q)
            2'b00:   s1_align_err = (s1_addr_q[1:0] != 2'b00);
            2'b01:   s1_align_err = s1_addr_q[0];
            2'b10:   s1_align_err = 1'b0;
            default: s1_align_err = 1'b1;   // reserved size code
        endcase
        s1_range_err = (s1_addr_q[31:MEM_AW] != '0);
        s1_err       = s1_align_err || s1_range_err;
    end

    // ------------------------------------------------------------------------
    // Memory port: driven straight from s1; the write only fires on adv so a
    // store blocked behind an unconsumed response is not repeated.
    // ------------------------------------------------------------------------
    assign bus.mem_addr = s1_addr_q[MEM_AW-1:0];
    assign bus.mem_din  = s1_wdata_q;
    assign bus.mem_size = s1_size_q;
    assign bus.mem_we   = adv && s1_we_q && !s1_err;

    // ------------------------------------------------------------------------
    // Load formatting: pick the addressed lane of the read word and extend.
    // ------------------------------------------------------------------------
    logic [7:0]  byte_raw;
    logic [15:0] half_raw;
    logic [31:0] load_fmt;

    always_comb begin
        byte_raw = 8'h00;
        unique case (s1_addr_q[1:0])
            2'd0:    byte_raw = bus.mem_dout[7:0];
            2'd1:    byte_raw = bus.mem_dout[15:8];
            2'd2:    byte_raw = bus.mem_dout[23:16];
            default: byte_raw = bus.mem_dout[31:24];
        endcase

        half_raw = s1_addr_q[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];

        load_fmt = 32'h0000_0000;
        unique case (s1_size_q)
            2'b00: load_fmt = bus.mem_dout;
            2'b01: load_fmt = s1_unsigned_q ? {16'h0000, half_raw}
                                            : {{16{half_raw[15]}}, half_raw};
            2'b10: load_fmt = s1_unsigned_q ? {24'h00_0000, byte_raw}
                                            : {{24{byte_raw[7]}}, byte_raw};
            default: load_fmt = 32'h0000_0000;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------------
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_we_d       = s1_we_q;
        s1_size_d     = s1_size_q;
        s1_unsigned_d = s1_unsigned_q;
        s1_addr_d     = s1_addr_q;
        s1_wdata_d    = s1_wdata_q;

        resp_valid_d  = resp_valid_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;

        // s1: a new request replaces the one leaving, so no bubble at full rate
        if (accept) begin
            s1_valid_d    = 1'b1;
            s1_we_d       = bus.req_we;
            s1_size_d     = bus.req_size;
            s1_unsigned_d = bus.req_unsigned;
            s1_addr_d     = bus.req_addr;
            s1_wdata_d    = bus.req_wdata;
        end else if (adv) begin
            s1_valid_d    = 1'b0;
        end

        // resp: an advancing request overwrites a response consumed this cycle;
        // otherwise data and err hold their last values after consumption.
        if (adv) begin
            resp_valid_d = 1'b1;
            resp_err_d   = s1_err;
            resp_rdata_d = (!s1_we_q && !s1_err) ? load_fmt : 32'h0000_0000;
        end else if (bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_we_q       <= 1'b0;
            s1_size_q     <= 2'b00;
            s1_unsigned_q <= 1'b0;
            s1_addr_q     <= 32'h0000_0000;
            s1_wdata_q    <= 32'h0000_0000;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'h0000_0000;
            resp_err_q    <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_we_q       <= s1_we_d;
            s1_size_q     <= s1_size_d;
            s1_unsigned_q <= s1_unsigned_d;
            s1_addr_q     <= s1_addr_d;
            s1_wdata_q    <= s1_wdata_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Response outputs
    // ------------------------------------------------------------------------
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// ----------------------------------------------------------------------------
// tb_lsu_mem_port
//
// Drives lsu_mem_port through its interface, plays a 4 KB byte-array data
// memory, and checks every response against a sequential reference model:
// each accepted request is executed immediately on a reference byte array,
// and the resulting (err, rdata) is queued until the matching response.
// ----------------------------------------------------------------------------
module tb_lsu_mem_port;

    localparam int unsigned AW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    lsu_mem_port_if #(.MEM_AW(AW)) bus ();

    lsu_mem_port #(.MEM_AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    int checks = 0;
    int errors = 0;
    int writes = 0;

    logic [7:0] tb_mem  [4096];
    logic [7:0] ref_mem [4096];
    logic [7:0] snap    [4096];

    rsp_t exp_q[$];
    rsp_t log_q[$];

    bit   rand_ready = 1'b0;

    // ------------------------------------------------------------------------
    // Data memory model: combinational read, write on the rising edge
    // ------------------------------------------------------------------------
    logic [11:0] rd_base;
    assign rd_base = {bus.mem_addr[11:2], 2'b00};

    always_comb begin
        bus.mem_dout = {tb_mem[rd_base + 12'd3], tb_mem[rd_base + 12'd2],
                        tb_mem[rd_base + 12'd1], tb_mem[rd_base]};
    end

    logic        wr_pend = 1'b0;
    logic [11:0] wr_addr;
    logic [31:0] wr_din;
    logic [1:0]  wr_size;

    always @(posedge clk) begin
        if (wr_pend && rst_n) begin
            case (wr_size)
                2'b00: begin
                    tb_mem[{wr_addr[11:2], 2'b00}] <= wr_din[7:0];
                    tb_mem[{wr_addr[11:2], 2'b01}] <= wr_din[15:8];
                    tb_mem[{wr_addr[11:2], 2'b10}] <= wr_din[23:16];
                    tb_mem[{wr_addr[11:2], 2'b11}] <= wr_din[31:24];
                end
                2'b01: begin
                    tb_mem[{wr_addr[11:1], 1'b0}] <= wr_din[7:0];
                    tb_mem[{wr_addr[11:1], 1'b1}] <= wr_din[15:8];
                end
                2'b10:   tb_mem[wr_addr] <= wr_din[7:0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : 1;
    endfunction

    function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
        if (addr >= 32'd4096) return 1'b1;
        case (size)
            2'b00:   return (addr % 4) != 0;
            2'b01:   return (addr % 2) != 0;
            2'b10:   return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr);
        int          n = nbytes(size);
        logic [31:0] v = 0;
        logic [31:0] mask;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr[11:0] + 12'(i)]) << (8 * i));
        if (n == 4) return v;
        mask = (32'd1 << (8 * n)) - 32'd1;
        if (!uns && ((v >> (8 * n - 1)) & 32'd1) != 0) v = v | ~mask;
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
        int n = nbytes(size);
        for (int i = 0; i < n; i++) ref_mem[addr[11:0] + 12'(i)] = 8'(wdata >> (8 * i));
    endtask

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic chk_log(input int idx, input logic [31:0] rd, input logic er);
        checks++;
        assert (idx < log_q.size()) else begin
            errors++;
            $error("FAIL log_missing observed %0d responses expected index %0d", log_q.size(), idx);
        end
        if (idx < log_q.size()) begin
            chk($sformatf("log%0d_rdata", idx), log_q[idx].rdata, rd);
            chk($sformatf("log%0d_err", idx), {31'b0, log_q[idx].err}, {31'b0, er});
        end
    endtask

    // One clock: inputs settled at posedge+1, everything sampled at negedge.
    task automatic cycle(output logic acc);
        logic rsp;
        rsp_t e;
        rsp_t got;
        if (rand_ready) bus.resp_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = bus.req_valid && bus.req_ready && rst_n;
        rsp = bus.resp_valid && bus.resp_ready && rst_n;
        wr_pend = bus.mem_we;
        wr_addr = bus.mem_addr;
        wr_din  = bus.mem_din;
        wr_size = bus.mem_size;
        if (bus.mem_we) writes++;
        if (rsp) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL resp_unexpected observed response expected none");
            end
            got.err   = bus.resp_err;
            got.rdata = bus.resp_rdata;
            log_q.push_back(got);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("resp_err", {31'b0, got.err}, {31'b0, e.err});
                chk("resp_rdata", got.rdata, e.rdata);
            end
        end
        if (acc) begin
            e.err   = ref_err(bus.req_size, bus.req_addr);
            e.rdata = (!bus.req_we && !e.err)
                    ? ref_load(bus.req_size, bus.req_unsigned, bus.req_addr) : 32'h0;
            if (bus.req_we && !e.err) ref_store(bus.req_size, bus.req_addr, bus.req_wdata);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        wr_pend = 1'b0;
    endtask

    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, output int ncyc);
        logic acc;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        ncyc = 0;
        acc  = 1'b0;
        while (!acc && ncyc < 60) begin
            cycle(acc);
            ncyc++;
        end
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL send_timeout observed no accept expected accept within 60 cycles");
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        int   n = 0;
        rand_ready     = 1'b0;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        while (exp_q.size() > 0 && n < 20) begin
            cycle(acc);
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int   n;
        int   cyc;
        int   w0;
        int   idx;
        int   bad;
        logic acc;
        logic [1:0]  sz;
        logic [31:0] ad;
        int   r;

        for (int i = 0; i < 4096; i++) begin
            tb_mem[i]  = 8'h00;
            ref_mem[i] = 8'h00;
        end
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h10;
        bus.req_wdata    = 32'h1234_5678;
        bus.resp_ready   = 1'b1;

        // Reset with a request pending on the bus
        #3;
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b1;

        // Store word then every load flavour, back-to-back
        log_q.delete();
        cyc = 0;
        send(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF, n); cyc += n;
        send(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, n);         cyc += n;
        send(1'b0, 2'b10, 1'b1, 32'h13, 32'h0, n);         cyc += n;
        send(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, n);         cyc += n;
        send(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, n);         cyc += n;
        send(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, n);         cyc += n;
        chk("throughput_cycles", 32'(cyc), 32'd6);
        drain();
        chk("t1_count", 32'(log_q.size()), 32'd6);
        chk_log(0, 32'h0000_0000, 1'b0);
        chk_log(1, 32'hFFFF_FFDE, 1'b0);
        chk_log(2, 32'h0000_00DE, 1'b0);
        chk_log(3, 32'hFFFF_DEAD, 1'b0);
        chk_log(4, 32'h0000_DEAD, 1'b0);
        chk_log(5, 32'hDEAD_BEEF, 1'b0);

        // Sub-word stores into a cleared word
        log_q.delete();
        send(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_0000, n);
        send(1'b1, 2'b10, 1'b0, 32'h11, 32'h0000_0055, n);
        send(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, n);
        send(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_A5A5, n);
        send(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, n);
        drain();
        chk_log(2, 32'h0000_5500, 1'b0);
        chk_log(4, 32'hA5A5_5500, 1'b0);

        // Illegal accesses never reach the memory
        log_q.delete();
        w0 = writes;
        send(1'b1, 2'b00, 1'b0, 32'h2,    32'hFFFF_FFFF, n);
        send(1'b0, 2'b01, 1'b0, 32'h5,    32'h0, n);
        send(1'b1, 2'b11, 1'b0, 32'h20,   32'hFFFF_FFFF, n);
        send(1'b0, 2'b00, 1'b0, 32'h1000, 32'h0, n);
        drain();
        for (int i = 0; i < 4; i++) chk_log(i, 32'h0, 1'b1);
        chk("illegal_writes", 32'(writes - w0), 32'd0);

        // Backpressure: 4 back-to-back stores, response held off for 5 cycles
        log_q.delete();
        w0  = writes;
        idx = 0;
        bus.resp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.req_valid    = 1'b1;
            bus.req_we       = 1'b1;
            bus.req_size     = 2'b00;
            bus.req_unsigned = 1'b0;
            bus.req_addr     = 32'h40 + 32'(4 * idx);
            bus.req_wdata    = 32'hC0DE_0000 + 32'(idx);
            cycle(acc);
            if (acc) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("bp_writes", 32'(writes - w0), 32'd1);
        bus.resp_ready = 1'b1;
        while (idx < 4) begin
            send(1'b1, 2'b00, 1'b0, 32'h40 + 32'(4 * idx), 32'hC0DE_0000 + 32'(idx), n);
            idx++;
        end
        drain();
        chk("bp_writes_total", 32'(writes - w0), 32'd4);
        chk("bp_acks", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk_log(i, 32'h0, 1'b0);

        // Reset while a store waits in s1 behind a held load response
        w0 = writes;
        bus.resp_ready = 1'b0;
        send(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, n);
        snap = ref_mem;
        send(1'b1, 2'b00, 1'b0, 32'h84, 32'h1234_5678, n);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        exp_q.delete();
        ref_mem = snap;
        cycle(acc);
        cycle(acc);
        rst_n = 1'b1;
        #1;
        chk("arst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("arst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("arst_resp_err", {31'b0, bus.resp_err}, 32'd0);
        chk("arst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("arst_writes", 32'(writes - w0), 32'd0);

        // Randomized traffic with random response backpressure
        rand_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            r  = int'($urandom_range(0, 7));
            sz = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
            ad = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) != 0) begin
                if (sz == 2'b00) ad = ad & ~32'd3;
                if (sz == 2'b01) ad = ad & ~32'd1;
            end
            if ($urandom_range(0, 15) == 0) ad = ad | (32'h1000 << $urandom_range(0, 19));
            send(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, n);
            if ($urandom_range(0, 3) == 0) begin
                bus.req_valid = 1'b0;
                cycle(acc);
            end
        end
        drain();

        // Whole memory must match the sequential model
        bad = 0;
        for (int i = 0; i < 4096; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
        chk("mem_image_mismatches", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed no completion expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit between the CPU MEM stage and the 4 KB data memory. Accepts one load or store request per cycle over a valid/ready handshake, drives the data memory's word-addressed port with the store size code, and returns an ordered response: a write ack for stores, or a sign/zero-extended and byte-lane-aligned word for loads. Misaligned, out-of-range or reserved-size accesses are blocked and flagged. It is the initiator side of the data memory port, and also provides load formatting, which the memory itself does not.

## Interface

- MEM_AW, 12: data memory byte-address width (4 KB)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 word, 01 half, 10 byte, 11 reserved (same code as memory store-size input)
- req_unsigned  in  1  loads only: 1 = zero-extend (lbu/lhu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- mem_addr  out  MEM_AW  to memory addr; equals held s1 address bits [MEM_AW-1:0]
- mem_din  out  32  to memory din; held s1 wdata, unshifted
- mem_we  out  1  memory write enable
- mem_size  out  2  to memory store-size select; held s1 size
- mem_dout  in  32  combinational memory read word at mem_addr
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid && resp_ready
- resp_rdata  out  32  formatted load data; 0 for stores and errors
- resp_err  out  1  access rejected

## Operation

- Two slots: s1 (accepted request: valid, we, size, unsigned, addr, wdata) and resp (valid, rdata, err).
- adv = s1_valid && (!resp_valid || resp_ready). req_ready = !s1_valid || adv (combinational).
- On accept: s1 loads request fields, s1_valid = 1. On adv with no accept: s1_valid = 0.
- err = size==11 || (size==01 && addr[0]) || (size==00 && addr[1:0]!=0) || addr[31:MEM_AW]!=0.
- mem_we = adv && s1_we && !err. This gives exactly one write per store, never repeated while stalled.
- Load format, with lane k = addr[1:0]:
  - word: mem_dout.
  - half: addr[1] ? [31:16] : [15:0].
  - byte: mem_dout[8k+7:8k].
  - Extension is sign, or zero if unsigned.
- On adv: resp_valid = 1, resp_err = err, resp_rdata = (load && !err) ? formatted : 0.
- Else if resp_ready: resp_valid = 0. resp_rdata and resp_err then hold their last values.
- Responses leave in acceptance order. At most 2 requests are in flight.

## Timing

- Reset (async assert, sync-free release): s1_valid=0, resp_valid=0, resp_rdata=0, resp_err=0. Therefore mem_we=0 and req_ready=1.
- Latency: request accepted at edge N; memory read/write occurs in cycle N..N+1 (write at edge N+1); resp_valid high from edge N+1.
- resp_ready held high: full throughput, 1 request/cycle, back-to-back.
- Backpressure: while resp_valid && !resp_ready, s1 holds and mem_we=0. req_ready = !s1_valid.
- Simultaneous resp consume and new adv: resp is overwritten with the next response, with no bubble.
- Store followed by load to the same word, back-to-back: the load samples mem_dout in the cycle after the store's write edge and sees the new data.
- Reset mid-operation: pending s1 and resp are dropped. No write is issued after rst_n falls.

## Test plan

- Reset: rst_n=0 with req_valid=1 -> req_ready=1, resp_valid=0, mem_we=0, resp_rdata=0.
- Store word 0xDEADBEEF to addr 0x10, then lb/lbu/lh/lhu/lw at 0x13/0x13/0x12/0x12/0x10:
  - lb/lbu -> 0xFFFFFFDE / 0x000000DE.
  - lh/lhu -> 0xFFFFDEAD / 0x0000DEAD.
  - lw -> 0xDEADBEEF.
  - All responses in order, resp_err=0.
- sb 0x55 to 0x11 after word 0x00000000 -> lw 0x10 returns 0x00005500. sh 0xA5A5 to 0x12 -> lw returns 0xA5A55500.
- Misaligned/illegal: sw to 0x2, lh at 0x5, size 11, lw at 0x1000 -> resp_err=1, rdata=0, mem_we never asserted, memory unchanged.
- Backpressure: 4 back-to-back stores with resp_ready=0 for 5 cycles -> exactly 2 accepted, req_ready=0, exactly one mem_we pulse (first store). After resp_ready=1: all 4 acks in order, 4 writes total.
- Async reset asserted while s1 holds a pending store -> no mem_we pulse. After release, the outputs equal their reset values.
